// File: rtl/cache_assoc_ctrl.sv
// N-way set-associative write-back/write-allocate cache controller with true-LRU
// replacement, a line-wide request/acknowledge memory port and hit/miss counters.
module cache_assoc_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SETS       = 4,
    parameter int NUM_WAYS       = 2,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                               clk,
    input  logic                               resetN,
    input  logic [ADDR_WIDTH-1:0]              inputAddress,
    input  logic [DATA_WIDTH-1:0]              inputData,
    input  logic                               loadEnable,
    input  logic                               storeEnable,
    output logic                               readyWire,
    output logic                               validWire,
    output logic [DATA_WIDTH-1:0]              dataOut,
    output logic                               storeCompleted,
    output logic [ADDR_WIDTH-1:0]              memAddress,
    output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] memWriteData,
    output logic                               memRead,
    output logic                               memWrite,
    input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] memReadData,
    input  logic                               memAck,
    output logic [31:0]                        hitCount,
    output logic [31:0]                        missCount
);
    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDR_WIDTH - 2 - OFF_W - IDX_W;
    localparam int LINE_W = DATA_WIDTH * WORDS_PER_LINE;
    localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
    typedef logic [NUM_WAYS-1:0][WAY_W-1:0] age_vec_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-3:0] req_waddr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  req_store;
    logic [WAY_W-1:0]      way_r;

    logic [TAG_W-1:0]  tags  [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0] lines [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty [NUM_SETS];
    age_vec_t            ages  [NUM_SETS];

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_word;
    logic             hit;
    logic [WAY_W-1:0] hit_way, victim;
    logic             found_inv;
    logic             unused_bits;

    assign req_word    = req_waddr[OFF_W-1:0];
    assign req_idx     = req_waddr[OFF_W +: IDX_W];
    assign req_tag     = req_waddr[ADDR_WIDTH-3 -: TAG_W];
    assign unused_bits = ^inputAddress[1:0];

    // Accessed way becomes age 0; everything younger than it ages by one.
    function automatic age_vec_t lru_touch(input age_vec_t a, input logic [WAY_W-1:0] w);
        lru_touch = a;
        for (int v = 0; v < NUM_WAYS; v++)
            if (a[v] < a[w]) lru_touch[v] = a[v] + 1'b1;
        lru_touch[w] = '0;
    endfunction

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        victim    = '0;
        found_inv = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!valid[req_idx][w] && !found_inv) begin
                found_inv = 1'b1;
                victim    = WAY_W'(w);
            end
        end
        // Ages are a permutation, so exactly one way holds the oldest age.
        if (!found_inv)
            for (int w = 0; w < NUM_WAYS; w++)
                if (ages[req_idx][w] == WAY_W'(NUM_WAYS - 1)) victim = WAY_W'(w);
    end

    always_ff @(posedge clk) begin
        if (!resetN) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next     = state;
        readyWire      = 1'b0;
        validWire      = 1'b0;
        storeCompleted = 1'b0;
        memRead        = 1'b0;
        memWrite       = 1'b0;
        memAddress     = '0;
        memWriteData   = '0;
        case (state)
            IDLE: begin
                readyWire = 1'b1;
                if (loadEnable || storeEnable) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (hit)                                      state_next = RESPOND;
                else if (valid[req_idx][victim] && dirty[req_idx][victim]) state_next = WRITEBACK;
                else                                          state_next = REFILL;
            end
            WRITEBACK: begin
                memWrite     = 1'b1;
                memAddress   = {tags[req_idx][way_r], req_idx, {(OFF_W+2){1'b0}}};
                memWriteData = lines[req_idx][way_r];
                if (memAck) state_next = REFILL;
            end
            REFILL: begin
                memRead    = 1'b1;
                memAddress = {req_tag, req_idx, {(OFF_W+2){1'b0}}};
                if (memAck) state_next = RESPOND;
            end
            RESPOND: begin
                validWire      = !req_store;
                storeCompleted = req_store;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            req_waddr <= '0;
            req_data  <= '0;
            req_store <= 1'b0;
            way_r     <= '0;
            dataOut   <= '0;
            hitCount  <= '0;
            missCount <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) ages[s][w] <= WAY_W'(w);
            end
        end else begin
            case (state)
                IDLE: if (loadEnable || storeEnable) begin
                    req_waddr <= inputAddress[ADDR_WIDTH-1:2];
                    req_data  <= inputData;
                    req_store <= storeEnable;
                end
                LOOKUP: if (hit) begin
                    way_r         <= hit_way;
                    ages[req_idx] <= lru_touch(ages[req_idx], hit_way);
                    if (hitCount != '1) hitCount <= hitCount + 32'd1;
                    if (!req_store) dataOut <= lines[req_idx][hit_way][req_word*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    way_r <= victim;
                    if (missCount != '1) missCount <= missCount + 32'd1;
                end
                WRITEBACK: if (memAck) dirty[req_idx][way_r] <= 1'b0;
                REFILL: if (memAck) begin
                    lines[req_idx][way_r] <= memReadData;
                    tags[req_idx][way_r]  <= req_tag;
                    valid[req_idx][way_r] <= 1'b1;
                    dirty[req_idx][way_r] <= 1'b0;
                    ages[req_idx]         <= lru_touch(ages[req_idx], way_r);
                    if (!req_store) dataOut <= memReadData[req_word*DATA_WIDTH +: DATA_WIDTH];
                end
                RESPOND: if (req_store) begin
                    lines[req_idx][way_r][req_word*DATA_WIDTH +: DATA_WIDTH] <= req_data;
                    dirty[req_idx][way_r] <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// Bench for cache_assoc_ctrl: timestamp-LRU cache model predicts a per-cycle
// output script for every request; a fixed-latency RAM answers the memory port.
module tb_cache_assoc_ctrl;
    localparam int NS = 4, NW = 2, WPL = 4, MEM_LAT = 3;

    logic         clk, resetN;
    logic [31:0]  inputAddress, inputData;
    logic         loadEnable, storeEnable;
    logic         readyWire, validWire, storeCompleted, memRead, memWrite, memAck;
    logic [31:0]  dataOut, memAddress, hitCount, missCount;
    logic [127:0] memWriteData, memReadData;

    cache_assoc_ctrl dut (
        .clk(clk), .resetN(resetN), .inputAddress(inputAddress), .inputData(inputData),
        .loadEnable(loadEnable), .storeEnable(storeEnable), .readyWire(readyWire),
        .validWire(validWire), .dataOut(dataOut), .storeCompleted(storeCompleted),
        .memAddress(memAddress), .memWriteData(memWriteData), .memRead(memRead),
        .memWrite(memWrite), .memReadData(memReadData), .memAck(memAck),
        .hitCount(hitCount), .missCount(missCount)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        bit ready, rd, wr, vld, sc;
        logic [31:0] addr;
        logic [127:0] wdata;
        logic [31:0] dout, hits, misses;
    } rec_t;
    typedef struct { string name; logic [127:0] act, exp; } lit_t;

    rec_t exp_q[$];
    lit_t lit_q[$];
    int   tests = 0, fails = 0;
    bit   cmp_en = 0;
    int   inject_req = 0, inject_done = 0;
    logic [31:0]  seen_wb_addr = 0;
    logic [127:0] seen_wb_data = 0;

    // ---------------- reference model ----------------
    bit          mv [NS][NW];
    bit          md [NS][NW];
    logic [31:0] mt [NS][NW];
    logic [31:0] mdat [NS][NW][WPL];
    int          mlast [NS][NW];
    int          tick = 0;
    logic [31:0] m_hits = 0, m_misses = 0, m_dout = 0;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ram [logic [31:0]];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : a + 32'd1;
    endfunction
    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : a + 32'd1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                mv[s][w] = 0; md[s][w] = 0; mlast[s][w] = 0;
            end
        m_hits = 0; m_misses = 0; m_dout = 0;
    endtask

    task automatic model_access(input logic [31:0] addr, input bit st, input logic [31:0] d,
                                output bit hit, output bit wb, output logic [31:0] wb_addr,
                                output logic [127:0] wb_data, output logic [31:0] rf_addr);
        logic [31:0] a, tag;
        int s, w, wd;
        a = addr & 32'hFFFF_FFFC;
        s = int'((a >> 4) % NS);
        wd = int'((a >> 2) % WPL);
        tag = a >> 6;
        rf_addr = a & 32'hFFFF_FFF0;
        hit = 0; wb = 0; wb_addr = 0; wb_data = 0; w = -1;
        for (int i = 0; i < NW; i++)
            if (mv[s][i] && mt[s][i] == tag) begin hit = 1; w = i; end
        if (hit) m_hits++;
        else begin
            m_misses++;
            for (int i = NW - 1; i >= 0; i--) if (!mv[s][i]) w = i;
            if (w < 0) begin
                w = 0;
                for (int i = 1; i < NW; i++) if (mlast[s][i] < mlast[s][w]) w = i;
            end
            if (mv[s][w] && md[s][w]) begin
                wb = 1;
                wb_addr = (mt[s][w] << 6) | (32'(s) << 4);
                for (int k = 0; k < WPL; k++) begin
                    wb_data[32*k +: 32] = mdat[s][w][k];
                    ref_mem[wb_addr + 32'(4*k)] = mdat[s][w][k];
                end
            end
            for (int k = 0; k < WPL; k++) mdat[s][w][k] = ref_rd(rf_addr + 32'(4*k));
            mv[s][w] = 1; mt[s][w] = tag; md[s][w] = 0;
        end
        tick++;
        mlast[s][w] = tick;
        if (st) begin mdat[s][w][wd] = d; md[s][w] = 1; end
        else m_dout = mdat[s][w][wd];
    endtask

    // ---------------- memory responder ----------------
    int wcnt = 0;
    initial begin memAck = 0; memReadData = 0; end
    always @(negedge clk) begin
        memAck = 0;
        if (inject_req != inject_done) begin
            memAck = 1; inject_done = inject_req; wcnt = 0;
        end else if (!resetN) wcnt = 0;
        else if (memRead || memWrite) begin
            wcnt++;
            if (wcnt == MEM_LAT) begin
                wcnt = 0; memAck = 1;
                for (int k = 0; k < WPL; k++)
                    if (memWrite) ram[memAddress + 32'(4*k)] = memWriteData[32*k +: 32];
                    else memReadData[32*k +: 32] = ram_rd(memAddress + 32'(4*k));
            end
        end else wcnt = 0;
    end

    // ---------------- single compare process ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rec_t r;
        lit_t l;
        while (lit_q.size() > 0) begin
            l = lit_q.pop_front();
            chk(l.name, l.act, l.exp);
        end
        if (exp_q.size() > 0) r = exp_q.pop_front();
        else begin
            r.ready = 1; r.rd = 0; r.wr = 0; r.vld = 0; r.sc = 0; r.addr = 0; r.wdata = 0;
            r.dout = m_dout; r.hits = m_hits; r.misses = m_misses;
        end
        if (cmp_en) begin
            chk("readyWire", 128'(readyWire), 128'(r.ready));
            chk("memRead", 128'(memRead), 128'(r.rd));
            chk("memWrite", 128'(memWrite), 128'(r.wr));
            chk("validWire", 128'(validWire), 128'(r.vld));
            chk("storeCompleted", 128'(storeCompleted), 128'(r.sc));
            chk("dataOut", 128'(dataOut), 128'(r.dout));
            chk("hitCount", 128'(hitCount), 128'(r.hits));
            chk("missCount", 128'(missCount), 128'(r.misses));
            if (r.rd || r.wr) chk("memAddress", 128'(memAddress), 128'(r.addr));
            if (r.wr) chk("memWriteData", memWriteData, r.wdata);
        end
        if (memWrite) begin seen_wb_addr = memAddress; seen_wb_data = memWriteData; end
    end

    // ---------------- stimulus ----------------
    task automatic lit(input string name, input logic [127:0] act, input logic [127:0] exp);
        lit_t l;
        l.name = name; l.act = act; l.exp = exp;
        lit_q.push_back(l);
    endtask

    task automatic issue(input logic [31:0] addr, input bit ld, input bit st, input logic [31:0] d);
        rec_t r;
        bit hit, wb;
        logic [31:0] wa, ra;
        logic [127:0] wdat;
        int n;
        r.ready = 1; r.rd = 0; r.wr = 0; r.vld = 0; r.sc = 0; r.addr = 0; r.wdata = 0;
        r.dout = m_dout; r.hits = m_hits; r.misses = m_misses;
        exp_q.push_back(r);
        r.ready = 0;
        exp_q.push_back(r);
        model_access(addr, st, d, hit, wb, wa, wdat, ra);
        r.hits = m_hits; r.misses = m_misses;
        if (!hit) begin
            if (wb) begin
                r.wr = 1; r.addr = wa; r.wdata = wdat;
                repeat (MEM_LAT) exp_q.push_back(r);
                r.wr = 0; r.wdata = 0;
            end
            r.rd = 1; r.addr = ra;
            repeat (MEM_LAT) exp_q.push_back(r);
            r.rd = 0; r.addr = 0;
        end
        r.vld = !st; r.sc = st; r.dout = m_dout;
        exp_q.push_back(r);
        inputAddress = addr; inputData = d; loadEnable = ld; storeEnable = st;
        @(posedge clk); #1;
        loadEnable = 0; storeEnable = 0; inputAddress = $urandom; inputData = $urandom;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin @(posedge clk); #1; n++; end
        if (exp_q.size() > 0) begin
            lit("transaction_timeout", 128'(exp_q.size()), 128'(0));
            exp_q.delete();
        end
    endtask

    initial begin
        int n;
        resetN = 0; loadEnable = 0; storeEnable = 0; inputAddress = 0; inputData = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 resetN = 1;
        lit("rst_ready", 128'(readyWire), 128'(1));
        lit("rst_memRead", 128'(memRead), 128'(0));
        lit("rst_memWrite", 128'(memWrite), 128'(0));
        lit("rst_valid", 128'(validWire), 128'(0));
        lit("rst_storeCompleted", 128'(storeCompleted), 128'(0));
        lit("rst_dataOut", 128'(dataOut), 128'(0));
        lit("rst_hitCount", 128'(hitCount), 128'(0));
        lit("rst_missCount", 128'(missCount), 128'(0));
        lit("rst_memAddress", 128'(memAddress), 128'(0));
        lit("rst_memWriteData", memWriteData, 128'(0));
        cmp_en = 1;

        issue(32'h0C, 1, 0, 0);
        lit("t1_model", 128'(m_dout), 128'(32'h0D));
        lit("t1_dataOut", 128'(dataOut), 128'(32'h0D));
        lit("t1_missCount", 128'(missCount), 128'(1));
        issue(32'h04, 1, 0, 0);
        lit("t2_dataOut", 128'(dataOut), 128'(32'h05));
        lit("t2_hitCount", 128'(hitCount), 128'(1));
        issue(32'h00, 0, 1, 32'h38C0);
        issue(32'h00, 1, 0, 0);
        lit("t3_dataOut", 128'(dataOut), 128'(32'h38C0));
        lit("t3_hitCount", 128'(hitCount), 128'(3));
        issue(32'h40, 1, 0, 0);
        issue(32'h80, 1, 0, 0);
        lit("t4_wb_addr", 128'(seen_wb_addr), 128'(0));
        lit("t4_wb_word0", 128'(seen_wb_data[31:0]), 128'(32'h38C0));
        lit("t4_wb_word1", 128'(seen_wb_data[63:32]), 128'(32'h05));
        lit("t4_dataOut", 128'(dataOut), 128'(32'h81));
        issue(32'h40, 1, 0, 0);
        lit("t4_hitCount", 128'(hitCount), 128'(4));
        lit("t4_dataOut40", 128'(dataOut), 128'(32'h41));

        // Reset in the middle of a refill, then a stale acknowledge.
        cmp_en = 0;
        inputAddress = 32'h100; loadEnable = 1;
        @(posedge clk); #1 loadEnable = 0;
        n = 0;
        while (!memRead && n < 20) begin @(posedge clk); #1; n++; end
        lit("t5_saw_memRead", 128'(memRead), 128'(1));
        resetN = 0;
        @(posedge clk); #1 resetN = 1;
        lit("t5_memRead", 128'(memRead), 128'(0));
        lit("t5_ready", 128'(readyWire), 128'(1));
        lit("t5_hitCount", 128'(hitCount), 128'(0));
        lit("t5_missCount", 128'(missCount), 128'(0));
        inject_req++;
        @(posedge clk); #1;
        lit("t5_stale_ready", 128'(readyWire), 128'(1));
        lit("t5_stale_memRead", 128'(memRead), 128'(0));
        lit("t5_stale_valid", 128'(validWire), 128'(0));
        model_reset();
        cmp_en = 1;
        issue(32'h100, 1, 0, 0);
        lit("t5_missCount", 128'(missCount), 128'(1));
        lit("t5_dataOut", 128'(dataOut), 128'(32'h101));

        issue(32'h0C, 1, 1, 32'd7);
        lit("t6_dataOut_held", 128'(dataOut), 128'(32'h101));
        issue(32'h0C, 1, 0, 0);
        lit("t6_dataOut", 128'(dataOut), 128'(32'd7));

        for (int i = 0; i < 250; i++) begin
            int op;
            op = int'($urandom_range(0, 3));
            issue($urandom_range(0, 1023), op != 2, op >= 2, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(negedge clk);
        #1 $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cache_assoc_ctrl.md
Name: cache_assoc_ctrl

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache controller with true-LRU replacement. It is the successor to the fixed direct-mapped cache_and_ram block. The CPU side keeps the load/store interface with ready/valid/storeCompleted. The memory side is a line-wide request/acknowledge port, so any RAM model or arbiter can sit behind it. Hit/miss counters are included for performance benches.

Parameters:
ADDR_WIDTH, 32, byte-address width
DATA_WIDTH, 32, word width; word = DATA_WIDTH/8 bytes (must be 32)
NUM_SETS, 4, number of sets, power of 2, >=2
NUM_WAYS, 2, associativity, power of 2, 1..4
WORDS_PER_LINE, 4, words per line, power of 2, >=2

Ports:
clk  in  1  clock, rising edge
resetN  in  1  synchronous active-low reset
inputAddress  in  ADDR_WIDTH  byte address; bits[1:0] ignored
inputData  in  DATA_WIDTH  store data
loadEnable  in  1  load request
storeEnable  in  1  store request
readyWire  out  1  high in IDLE: request accepted on this edge
validWire  out  1  1-cycle pulse: dataOut holds load result
dataOut  out  DATA_WIDTH  load result; holds last value until next load
storeCompleted  out  1  1-cycle pulse: store written into cache
memAddress  out  ADDR_WIDTH  line-aligned byte address (offset bits zero)
memWriteData  out  DATA_WIDTH*WORDS_PER_LINE  victim line, word0 in LSBs
memRead  out  1  refill request, held until memAck
memWrite  out  1  writeback request, held until memAck
memReadData  in  DATA_WIDTH*WORDS_PER_LINE  refill line, sampled when memAck=1
memAck  in  1  1-cycle acknowledge of the current memRead/memWrite
hitCount  out  32  saturating hit counter
missCount  out  32  saturating miss counter

Behaviour:
- Address split, LSB to MSB: 2 byte bits | log2(WORDS_PER_LINE) word bits | log2(NUM_SETS) index bits | remaining bits = tag.
- Reset (resetN=0 at clk edge):
  - State=IDLE. All valid/dirty bits = 0. LRU ages per set: age[w]=w.
  - dataOut=0. validWire=storeCompleted=memRead=memWrite=0. memAddress=0, memWriteData=0. Counters=0. readyWire=1 after reset.
  - Reset mid-operation drops the pending request and any in-flight memory request. A late memAck is ignored.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE:
  - readyWire=1.
  - If loadEnable or storeEnable: latch address, data and op, then go to LOOKUP.
  - If both are high, the request is a store.
  - If neither is high, stay in IDLE.
- LOOKUP:
  - readyWire=0. Compare the tag against all valid ways in the set.
  - Hit: update LRU, hitCount+1, go to RESPOND.
  - Miss: missCount+1. Victim = lowest-index invalid way, else the way with the maximum age.
  - Dirty victim goes to WRITEBACK; clean victim goes to REFILL.
- WRITEBACK:
  - memWrite=1, memAddress={victim tag, index, 0}, memWriteData=victim line.
  - On memAck: clear dirty, go to REFILL.
- REFILL:
  - memRead=1, memAddress = line address of the request.
  - On memAck: write memReadData into the victim way, set valid, set tag, dirty=0, update LRU, go to RESPOND.
- RESPOND (one cycle, then IDLE):
  - Load: dataOut = selected word, validWire=1.
  - Store: write the word, dirty=1, storeCompleted=1.
- Latency:
  - Hit: validWire/storeCompleted is high in the 2nd cycle after the accepting edge.
  - Miss: hit latency + 1 + memory wait per transfer, plus the writeback if one is needed.
- LRU update on an access to way w: every age < age[w] is incremented, then age[w]=0. Ages always form a permutation of 0..NUM_WAYS-1.
- NUM_WAYS=1: always victim way 0; the LRU logic is degenerate.
- Counters saturate at 32'hFFFFFFFF with no wrap.
- memAck while memRead and memWrite are both low is ignored.
- The request inputs are don't-care outside IDLE.

Test Plan:
Bench: default parameters; the memory model acks 3 cycles after a request; the line at byte address A holds word k = A+4k+1.
1. Reset, load 0x0C -> miss; memRead with memAddress=0x00; validWire pulse, dataOut=0x0D; missCount=1, no memWrite.
2. Load 0x04 -> hit; validWire exactly 2 cycles after accept, dataOut=0x05; no memRead; hitCount=1.
3. Store 0x00 with data 0x38C0, then load 0x00 -> storeCompleted pulse with no memory traffic, then dataOut=0x38C0; hitCount=3.
4. Load 0x40 (miss, fills way1), then load 0x80.
   - Expect memWrite with memAddress=0x00 and memWriteData word0=0x38C0, word1=0x05.
   - Then memRead with 0x80; dataOut=0x81.
   - Load 0x40 still hits.
5. resetN=0 for one cycle while memRead=1 during a refill of 0x100 -> next cycle memRead=0, readyWire=1, counters=0. Stale memAck is ignored. Load 0x100 misses again.
6. loadEnable=storeEnable=1 at 0x0C with data 7 -> treated as store: miss refill, storeCompleted pulse, no validWire. A subsequent load 0x0C returns 7.
